// File: rtl/tm_dram_sched_pkg.sv
// Shared types and sizing for the target-time miss scheduler.
// Thread states, DRAM queue entry layout and latency helpers live here.
package tm_dram_sched_pkg;

  localparam int NTHREAD = 64;
  localparam int TIDW    = $clog2(NTHREAD);
  localparam int PEN_W   = 8;
  localparam int REM_W   = PEN_W + 1;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef enum logic [1:0] {
    TMS_IDLE,
    TMS_L2WAIT,
    TMS_DRAMQ,
    TMS_DRAMWAIT
  } tm_thread_mem_state_t;

  typedef struct packed {
    logic [TIDW-1:0] tid;
    logic            wb;
  } tm_dram_req_t;

  // A zero-latency configuration still costs one target cycle.
  function automatic logic [REM_W-1:0] max1(input logic [REM_W-1:0] x);
    return (x == '0) ? REM_W'(1) : x;
  endfunction

endpackage

// File: rtl/tm_dram_sched_if.sv
// Miss request bus from the L1 tag check into the scheduler.
interface tm_dram_sched_if;
  import tm_dram_sched_pkg::*;

  logic            req_valid;
  logic [TIDW-1:0] req_tid;
  logic            req_l2_hit;
  logic            req_wb;

  modport master (output req_valid, output req_tid, output req_l2_hit, output req_wb);
  modport slave  (input  req_valid, input  req_tid, input  req_l2_hit, input  req_wb);
endinterface

// File: rtl/tm_dram_fifo.sv
// Strict-order queue of threads waiting for the shared DRAM channel.
module tm_dram_fifo
  import tm_dram_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         enq,
  input  tm_dram_req_t enq_data,
  input  logic         deq,
  output tm_dram_req_t head,
  output logic         empty
);

  tm_dram_req_t    mem [NTHREAD];
  logic [TIDW-1:0] head_q, head_d, tail_q, tail_d;
  logic [TIDW:0]   count_q, count_d;
  logic            deq_ok;

  assign deq_ok = deq && !empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{TIDW{1'b0}}, enq} - {{TIDW{1'b0}}, deq_ok};
    if (enq)    tail_d = tail_q + 1'b1;
    if (deq_ok) head_d = head_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail_q] <= enq_data;
  end

  // Empty reflects the registered count, so a same-cycle push is never the head.
  assign head  = mem[head_q];
  assign empty = (count_q == '0);

endmodule

// File: rtl/tm_dram_sched.sv
// Per-thread miss latency model: L2 hit countdown plus a single shared
// DRAM channel with access time and channel cycle (occupancy) time.
module tm_dram_sched
  import tm_dram_sched_pkg::*;
(
  input  iu_clk_type            gclk,
  input  logic                  rstn,
  input  logic                  tick,
  tm_dram_sched_if.slave        req_if,
  input  logic [PEN_W-1:0]      l2_access_time,
  input  logic [PEN_W-1:0]      dram_access_time,
  input  logic [PEN_W-1:0]      dram_cycle_time,
  output logic [NTHREAD-1:0]    stay_stalled,
  output logic                  dram_busy,
  output logic                  proto_err
);

  logic             clk;
  logic [REM_W-1:0] chan_rem_q, chan_rem_d;
  logic             proto_err_q, proto_err_d;
  logic             req_idle, push, dispatch, fifo_empty;
  tm_dram_req_t     fifo_head, push_data;
  logic [REM_W-1:0] l2_lat, dram_lat, cyc_lat, chan_lat;

  assign clk = gclk.clk;

  assign req_idle  = !stay_stalled[req_if.req_tid];
  assign push      = req_if.req_valid && req_idle && !req_if.req_l2_hit;
  assign push_data = '{tid: req_if.req_tid, wb: req_if.req_wb};
  assign dispatch  = tick && (chan_rem_q == '0) && !fifo_empty;

  assign l2_lat   = max1({1'b0, l2_access_time});
  assign dram_lat = max1({1'b0, l2_access_time} + {1'b0, dram_access_time});
  assign cyc_lat  = max1({1'b0, dram_cycle_time});
  assign chan_lat = fifo_head.wb ? {cyc_lat[REM_W-2:0], 1'b0} : cyc_lat;

  tm_dram_fifo u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .enq      (push),
    .enq_data (push_data),
    .deq      (dispatch),
    .head     (fifo_head),
    .empty    (fifo_empty)
  );

  for (genvar gi = 0; gi < NTHREAD; gi++) begin : g_thr
    tm_thread_mem_state_t state_q, state_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic                 sel;

    assign sel = req_if.req_valid && (req_if.req_tid == TIDW'(gi));

    // A load outranks the tick, so a fresh counter is never decremented on arrival.
    always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      if (sel && state_q == TMS_IDLE) begin
        if (req_if.req_l2_hit) begin
          state_d = TMS_L2WAIT;
          rem_d   = l2_lat;
        end else begin
          state_d = TMS_DRAMQ;
        end
      end else if (dispatch && state_q == TMS_DRAMQ && fifo_head.tid == TIDW'(gi)) begin
        state_d = TMS_DRAMWAIT;
        rem_d   = dram_lat;
      end else if (tick && (state_q == TMS_L2WAIT || state_q == TMS_DRAMWAIT)) begin
        if (rem_q == REM_W'(1)) begin
          state_d = TMS_IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - REM_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= TMS_IDLE;
        rem_q   <= '0;
      end else begin
        state_q <= state_d;
        rem_q   <= rem_d;
      end
    end

    assign stay_stalled[gi] = (state_q != TMS_IDLE);
  end

  always_comb begin
    chan_rem_d  = chan_rem_q;
    proto_err_d = proto_err_q | (req_if.req_valid && !req_idle);
    if (tick) begin
      if (chan_rem_q != '0) chan_rem_d = chan_rem_q - REM_W'(1);
      else if (!fifo_empty)  chan_rem_d = chan_lat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chan_rem_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      chan_rem_q  <= chan_rem_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign dram_busy = (chan_rem_q != '0);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_tm_dram_sched.sv
// Directed scenario bench for tm_dram_sched with hand-derived tick counts.
module tb_tm_dram_sched;
  import tm_dram_sched_pkg::*;

  iu_clk_type          gclk;
  logic                rstn;
  logic                tick;
  logic [PEN_W-1:0]    l2_access_time, dram_access_time, dram_cycle_time;
  logic [NTHREAD-1:0]  stay_stalled;
  logic                dram_busy, proto_err;
  int                  tests_run = 0;
  int                  tests_failed = 0;

  tm_dram_sched_if req_if ();

  tm_dram_sched dut (
    .gclk             (gclk),
    .rstn             (rstn),
    .tick             (tick),
    .req_if           (req_if),
    .l2_access_time   (l2_access_time),
    .dram_access_time (dram_access_time),
    .dram_cycle_time  (dram_cycle_time),
    .stay_stalled     (stay_stalled),
    .dram_busy        (dram_busy),
    .proto_err        (proto_err)
  );

  initial gclk.clk = 1'b0;
  always #5 gclk.clk = ~gclk.clk;

  // One clock with the given inputs applied; outputs are sampled 1 time unit after the edge.
  task automatic drive(input bit v, input int tid, input bit hit, input bit wb, input bit tk);
    req_if.req_valid  = v;
    req_if.req_tid    = TIDW'(tid);
    req_if.req_l2_hit = hit;
    req_if.req_wb     = wb;
    tick              = tk;
    @(posedge gclk.clk);
    #1;
    req_if.req_valid = 1'b0;
    tick             = 1'b0;
  endtask

  task automatic do_tick();
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    tests_run++;
    if (stay_stalled !== '0 || dram_busy !== 1'b0 || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: stall=%h busy=%b perr=%b, required all zero", stay_stalled, dram_busy, proto_err);
    end
    rstn = 1'b1;
    drive(0, 0, 0, 0, 0);
    $display("[TB] reset: stall=%h busy=%b perr=%b", stay_stalled, dram_busy, proto_err);
  endtask

  task automatic test_l2_hit();
    l2_access_time = 8'd3;
    drive(1, 5, 1, 0, 0);
    $display("[TB] l2_hit req tid5: stall5=%b", stay_stalled[5]);
    tests_run++;
    if (stay_stalled[5] !== 1'b1) begin
      tests_failed++;
      $display("FAIL l2_hit_rise: stall5=%b required 1", stay_stalled[5]);
    end
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      $display("[TB] l2_hit tick %0d: stall5=%b", k, stay_stalled[5]);
      tests_run++;
      if (stay_stalled[5] !== (k < 3)) begin
        tests_failed++;
        $display("FAIL l2_hit_tick%0d: stall5=%b required %b", k, stay_stalled[5], k < 3);
      end
    end
  endtask

  task automatic test_single_dram();
    l2_access_time = 8'd2; dram_access_time = 8'd10; dram_cycle_time = 8'd4;
    drive(1, 0, 0, 0, 0);
    $display("[TB] dram req tid0: stall0=%b busy=%b", stay_stalled[0], dram_busy);
    tests_run++;
    if (stay_stalled[0] !== 1'b1 || dram_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL dram_queued: stall0=%b busy=%b required 1 0", stay_stalled[0], dram_busy);
    end
    for (int k = 1; k <= 14; k++) begin
      do_tick();
      $display("[TB] dram tick %0d: stall0=%b busy=%b", k, stay_stalled[0], dram_busy);
      tests_run++;
      if (stay_stalled[0] !== (k < 13) || dram_busy !== (k < 5)) begin
        tests_failed++;
        $display("FAIL dram_tick%0d: stall0=%b busy=%b required %b %b",
                 k, stay_stalled[0], dram_busy, k < 13, k < 5);
      end
    end
  endtask

  task automatic test_contention();
    drive(1, 1, 0, 0, 0);
    drive(1, 2, 0, 0, 0);
    drive(1, 3, 0, 0, 0);
    for (int k = 1; k <= 24; k++) begin
      logic [2:0] exp_st, got_st;
      logic       exp_busy;
      do_tick();
      exp_st   = {k < 23, k < 18, k < 13};
      got_st   = stay_stalled[3:1];
      exp_busy = (k % 5 != 0) && (k < 15);
      $display("[TB] contention tick %0d: stall321=%b busy=%b", k, got_st, dram_busy);
      tests_run++;
      if (got_st !== exp_st || dram_busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL contention_tick%0d: stall321=%b busy=%b required %b %b",
                 k, got_st, dram_busy, exp_st, exp_busy);
      end
    end
  endtask

  task automatic test_writeback();
    drive(1, 7, 0, 1, 0);
    drive(1, 8, 0, 0, 0);
    for (int k = 1; k <= 23; k++) begin
      logic exp_busy;
      do_tick();
      exp_busy = (k <= 8) || (k >= 10 && k <= 13);
      $display("[TB] wb tick %0d: stall7=%b stall8=%b busy=%b", k, stay_stalled[7], stay_stalled[8], dram_busy);
      tests_run++;
      if (stay_stalled[7] !== (k < 13) || stay_stalled[8] !== (k < 22) || dram_busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL wb_tick%0d: s7=%b s8=%b busy=%b required %b %b %b",
                 k, stay_stalled[7], stay_stalled[8], dram_busy, k < 13, k < 22, exp_busy);
      end
    end
  endtask

  task automatic test_simultaneous();
    l2_access_time = 8'd3;
    tests_run++;
    if (proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL perr_clean: perr=%b required 0", proto_err);
    end
    drive(1, 5, 1, 0, 1);
    drive(0, 0, 0, 0, 0);
    $display("[TB] simul req+tick tid5: stall5=%b", stay_stalled[5]);
    do_tick();
    drive(1, 5, 0, 1, 0);
    $display("[TB] simul dup tid5: perr=%b busy=%b", proto_err, dram_busy);
    tests_run++;
    if (proto_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL perr_set: perr=%b required 1", proto_err);
    end
    for (int k = 2; k <= 4; k++) begin
      do_tick();
      $display("[TB] simul tick %0d: stall5=%b busy=%b", k, stay_stalled[5], dram_busy);
      tests_run++;
      if (stay_stalled[5] !== (k < 3) || dram_busy !== 1'b0 || proto_err !== 1'b1) begin
        tests_failed++;
        $display("FAIL simul_tick%0d: stall5=%b busy=%b perr=%b required %b 0 1",
                 k, stay_stalled[5], dram_busy, proto_err, k < 3);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NTHREAD-1:0] exp_vec;
    l2_access_time = 8'd2; dram_access_time = 8'd10; dram_cycle_time = 8'd4;
    drive(1, 10, 1, 0, 0);
    drive(1, 11, 0, 0, 0);
    drive(1, 12, 0, 1, 0);
    drive(1, 13, 0, 0, 0);
    do_tick();
    do_tick();
    $display("[TB] pre-reset: stall=%h busy=%b", stay_stalled, dram_busy);
    #2 rstn = 1'b0;
    #1;
    $display("[TB] reset asserted: stall=%h busy=%b perr=%b", stay_stalled, dram_busy, proto_err);
    tests_run++;
    if (stay_stalled !== '0 || dram_busy !== 1'b0 || proto_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: stall=%h busy=%b perr=%b required all zero", stay_stalled, dram_busy, proto_err);
    end
    @(posedge gclk.clk);
    #1 rstn = 1'b1;
    drive(0, 0, 0, 0, 0);
    drive(1, 20, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      do_tick();
      exp_vec = '0;
      exp_vec[20] = (k < 13);
      $display("[TB] post-reset tick %0d: stall=%h busy=%b", k, stay_stalled, dram_busy);
      tests_run++;
      if (stay_stalled !== exp_vec || dram_busy !== (k < 5)) begin
        tests_failed++;
        $display("FAIL post_reset_tick%0d: stall=%h busy=%b required %h %b",
                 k, stay_stalled, dram_busy, exp_vec, k < 5);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; tick = 1'b0;
    req_if.req_valid = 1'b0; req_if.req_tid = '0; req_if.req_l2_hit = 1'b0; req_if.req_wb = 1'b0;
    l2_access_time = '0; dram_access_time = '0; dram_cycle_time = '0;
    test_reset();
    test_l2_hit();
    test_single_dram();
    test_contention();
    test_writeback();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
